// File: rtl/wu_pkg.sv
// Shared definitions for the delta_calc / WeightUpdate pair.
//   W, FRAC, LR_W : datapath width, activation fraction bits, LR shift width
//   state_t       : delta_calc controller states
//   sat_w()       : scale a 2W-bit product down and clamp it to W bits
package wu_pkg;

    localparam int W    = 10;
    localparam int FRAC = 5;
    localparam int LR_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        SAT  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Drops FRAC fraction bits plus the learning-rate shift (truncating),
    // then clamps to the largest W-bit magnitude.
    function automatic logic [W-1:0] sat_w(input logic [2*W-1:0] acc,
                                           input logic [LR_W-1:0] lr_shift);
        int              sh;
        logic [2*W-1:0]  r;
        sh = FRAC + int'(lr_shift);
        if (sh >= 2*W) begin
            return '0;
        end
        r = acc >> sh;
        if (|r[2*W-1:W]) begin
            return '1;
        end
        return r[W-1:0];
    endfunction

endpackage

// File: rtl/serial_mul.sv
// LSB-first shift-add multiplier, one multiplier bit per enabled cycle.
//   clk, rst : clock, synchronous active-high reset
//   start    : clears accumulator and bit counter
//   en       : process bit b[cnt] this cycle
//   a, b     : multiplicand / multiplier, held stable by the caller
//   acc      : running 2N-bit product
//   last     : high while the final multiplier bit is being processed
module serial_mul
    import wu_pkg::*;
#(
    parameter int N = W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic [2*N-1:0]   acc,
    output logic             last
);

    localparam int CW = $clog2(N);

    logic [CW-1:0] cnt;

    assign last = en && (cnt == CW'(N-1));

    always_ff @(posedge clk) begin
        if (rst || start) begin
            acc <= '0;
            cnt <= '0;
        end else if (en) begin
            if (b[cnt]) begin
                acc <= acc + ({{N{1'b0}}, a} << cnt);
            end
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/delta_calc.sv
// Sign-magnitude weight correction for WeightUpdate:
// delta = sat_W((err_mag * act) >> (FRAC + lr_shift)), sign = err_sign unless delta is 0.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (accepted only in IDLE)
//   err_mag, err_sign   : error magnitude and sign (1 = negative)
//   act                 : activation, unsigned Q(W-FRAC).FRAC
//   lr_shift            : learning rate 2^-lr_shift
//   out_valid/out_ready : result handshake
//   delta, sign         : correction, held until the next SAT or reset
//
// state | meaning
// IDLE  | waiting for an operand set, in_ready high
// MUL   | W cycles of serial shift-add
// SAT   | scale, saturate and register delta/sign
// DONE  | result presented until out_ready
module delta_calc
    import wu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     err_mag,
    input  logic             err_sign,
    input  logic [W-1:0]     act,
    input  logic [LR_W-1:0]  lr_shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     delta,
    output logic             sign
);

    state_t              state;
    logic [W-1:0]        err_mag_reg;
    logic                err_sign_reg;
    logic [W-1:0]        act_reg;
    logic [LR_W-1:0]     lr_reg;
    logic [2*W-1:0]      acc;
    logic                mul_last;
    logic                accept;
    logic [W-1:0]        delta_next;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign accept     = in_valid && in_ready;
    assign delta_next = sat_w(acc, lr_reg);

    serial_mul #(.N(W)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .en    (state == MUL),
        .a     (err_mag_reg),
        .b     (act_reg),
        .acc   (acc),
        .last  (mul_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            err_mag_reg  <= '0;
            err_sign_reg <= 1'b0;
            act_reg      <= '0;
            lr_reg       <= '0;
            delta        <= '0;
            sign         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        err_mag_reg  <= err_mag;
                        err_sign_reg <= err_sign;
                        act_reg      <= act;
                        lr_reg       <= lr_shift;
                        state        <= MUL;
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        state <= SAT;
                    end
                end
                SAT: begin
                    delta <= delta_next;
                    // A zero correction never carries a negative sign.
                    sign  <= err_sign_reg && (delta_next != '0);
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delta_calc.sv
module tb_delta_calc;

    localparam int W    = 10;
    localparam int FRAC = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [9:0]  err_mag = '0;
    logic        err_sign = 1'b0;
    logic [9:0]  act = '0;
    logic [2:0]  lr_shift = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [9:0]  delta;
    logic        sign;

    int n_total = 0;
    int n_pass  = 0;

    delta_calc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .err_mag   (err_mag),
        .err_sign  (err_sign),
        .act       (act),
        .lr_shift  (lr_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .delta     (delta),
        .sign      (sign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    endtask

    // Reference arithmetic: product, scale by 2^-(FRAC+lr), clamp, sign rule.
    function automatic int ref_delta(input int e, input int a, input int lr);
        longint prod;
        longint r;
        prod = longint'(e) * longint'(a);
        r    = prod / (longint'(1) << (FRAC + lr));
        return (r > 1023) ? 1023 : int'(r);
    endfunction

    // Transaction-level model: a busy countdown of W+1 cycles after accept,
    // then the result is held until out_ready.
    int  m_busy = 0;
    bit  m_hold = 0;
    int  m_delta = 0;
    bit  m_sign = 0;
    int  m_pend_delta = 0;
    bit  m_pend_sign = 0;
    bit  started = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy  = 0;
            m_hold  = 0;
            m_delta = 0;
            m_sign  = 0;
            started = 1;
        end else if (m_hold) begin
            if (out_ready) m_hold = 0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_delta = m_pend_delta;
                m_sign  = m_pend_sign;
                m_hold  = 1;
            end
        end else if (in_valid) begin
            m_busy       = W + 1;
            m_pend_delta = ref_delta(int'(err_mag), int'(act), int'(lr_shift));
            m_pend_sign  = err_sign && (m_pend_delta != 0);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("in_ready",  int'(in_ready),  int'(!m_hold && m_busy == 0));
            check("out_valid", int'(out_valid), int'(m_hold));
            check("delta",     int'(delta),     m_delta);
            check("sign",      int'(sign),      int'(m_sign));
        end
    end

    task automatic send(input int e, input bit es, input int a, input int lr);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("send_timeout", 1, 0);
        err_mag  = e[9:0];
        err_sign = es;
        act      = a[9:0];
        lr_shift = lr[2:0];
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Returns number of edges after accept until out_valid is seen, -1 on timeout.
    task automatic wait_out(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1 cycles++;
        end while (!out_valid && cycles < 60);
        if (!out_valid) begin
            check("wait_out_timeout", 1, 0);
            cycles = -1;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_delta", int'(delta), 0);
        check("rst_sign", int'(sign), 0);

        // model pins
        check("model_basic", ref_delta(50, 32, 2), 12);
        check("model_sat", ref_delta(1023, 1023, 0), 1023);
        check("model_bigshift", ref_delta(1023, 1023, 7), 255);

        // 1: basic, latency
        send(50, 1, 32, 2);
        wait_out(cyc);
        check("basic_latency", cyc, 11);
        check("basic_delta", int'(delta), 12);
        check("basic_sign", int'(sign), 1);
        release_out();

        // 2: saturation
        send(1023, 0, 1023, 0);
        wait_out(cyc);
        check("sat_delta", int'(delta), 1023);
        check("sat_sign", int'(sign), 0);
        release_out();

        // 3: zero product forces sign low
        send(700, 1, 0, 1);
        wait_out(cyc);
        check("zero_delta", int'(delta), 0);
        check("zero_sign", int'(sign), 0);
        release_out();

        // largest shift
        send(1023, 1, 1023, 7);
        wait_out(cyc);
        check("shift7_delta", int'(delta), 255);
        check("shift7_sign", int'(sign), 1);
        release_out();

        // 4: back-pressure with ignored input pulse
        send(50, 1, 32, 2);
        wait_out(cyc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) begin
                err_mag = 10'd999; act = 10'd999; err_sign = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_delta", int'(delta), 12);
            check("bp_sign", int'(sign), 1);
            check("bp_in_ready", int'(in_ready), 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_release_out_valid", int'(out_valid), 0);

        // 5: reset during MUL
        send(300, 0, 64, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("mrst_in_ready", int'(in_ready), 1);
        check("mrst_out_valid", int'(out_valid), 0);
        check("mrst_delta", int'(delta), 0);
        check("mrst_sign", int'(sign), 0);
        send(100, 0, 32, 0);
        wait_out(cyc);
        check("mrst_latency", cyc, 11);
        check("mrst_next_delta", int'(delta), 100);
        check("mrst_next_sign", int'(sign), 0);
        release_out();

        // 6: back-to-back with out_ready tied high
        @(negedge clk);
        out_ready = 1'b1;
        send(64, 0, 96, 1);
        repeat (4) @(posedge clk);
        #1 check("b2b_busy_in_ready", int'(in_ready), 0);
        wait_out(cyc);
        check("b2b_first_delta", int'(delta), 96);
        send(10, 0, 16, 0);
        repeat (4) @(posedge clk);
        #1 check("b2b_busy2_in_ready", int'(in_ready), 0);
        wait_out(cyc);
        check("b2b_second_delta", int'(delta), 5);
        check("b2b_second_sign", int'(sign), 0);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/delta_calc.md
Name: delta_calc

Overview:
Computes the sign-magnitude weight correction (delta, sign) consumed directly by the WeightUpdate stage, which forms weight_new = weight ± delta.
- delta = (err_mag × act) scaled by the fixed-point fraction and the learning-rate shift, then saturated to W bits.
- Uses a serial shift-add multiplier behind a valid/ready handshake, so one correction is produced per W+1 cycles with minimal area.

Parameters:
W, 10, width of err_mag, act and delta (matches WeightUpdate weight/delta width)
FRAC, 5, fractional bits of act (act = 2^FRAC represents 1.0)
LR_W, 3, width of the learning-rate shift port

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  err/act/lr_shift valid
in_ready  output  1  block can accept an operand set
err_mag  input  W  error magnitude, unsigned
err_sign  input  1  error sign (1 = negative)
act  input  W  activation, unsigned, Q(W-FRAC).FRAC
lr_shift  input  LR_W  learning rate = 2^-lr_shift
out_valid  output  1  delta/sign valid
out_ready  input  1  downstream accepts result
delta  output  W  saturated correction magnitude, feeds WeightUpdate delta
sign  output  1  correction sign, feeds WeightUpdate sign

Behaviour:
- Reset (synchronous, active-high): state IDLE; in_ready=1; out_valid=0; delta=0; sign=0; accumulator and counter cleared.
- Reset mid-operation: rst has priority in every state. The next cycle is IDLE with reset outputs. The partial result is discarded.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture err_mag, err_sign, act and lr_shift; clear the 2W-bit accumulator; set cnt=0; go to MUL.
- MUL (in_ready=0): runs W cycles, LSB-first.
  - If act_reg[cnt]=1, then acc += err_mag << cnt.
  - cnt increments each cycle.
  - On the cycle cnt=W-1 is processed, go to SAT.
- SAT (in_ready=0): one cycle.
  - r = acc >> (FRAC + lr_shift_reg), truncating.
  - delta <= (r > 2^W-1) ? 2^W-1 : r[W-1:0].
  - sign <= err_sign_reg && (delta_next != 0), i.e. a zero delta always has sign 0.
  - Go to DONE.
- DONE:
  - out_valid=1; delta and sign held stable.
  - While out_ready=0, remain in DONE; outputs do not change.
  - On out_ready=1, go to IDLE. out_valid drops next cycle and in_ready rises next cycle; there is no same-cycle accept.
- Latency: accept at edge k gives out_valid=1 after edge k+W+1 (W+1 cycles). Minimum initiation interval is W+3 cycles.
- Width rules:
  - The accumulator is 2W bits; no overflow is possible.
  - Shift range is 0..FRAC+2^LR_W-1; shifts ≥ 2W yield 0.
- in_valid or operand changes outside IDLE are ignored.
- delta and sign change only in SAT or on reset.

Decomposition:
- Shared package wu_pkg holds:
  - localparams W, FRAC, LR_W, shared with WeightUpdate;
  - enum state_t {IDLE, MUL, SAT, DONE};
  - function sat_w() for shift-and-saturate.
- Optional sub-module serial_mul holds the accumulator, counter and shift-add datapath with start/done. The FSM, saturation and handshake stay in delta_calc.

Test Plan:
All scenarios use defaults W=10, FRAC=5.
1. Basic: err_mag=50, err_sign=1, act=32 (1.0), lr_shift=2 -> acc=1600, delta=12, sign=1. out_valid rises exactly 11 cycles after accept.
2. Saturation: err_mag=1023, act=1023, lr_shift=0, err_sign=0 -> r=32704 -> delta=1023, sign=0.
3. Zero product: err_mag=700, err_sign=1, act=0, lr_shift=1 -> delta=0, sign=0 (sign forced low).
4. Back-pressure: case 1, then out_ready=0 for 5 cycles -> out_valid stays 1, delta=12/sign=1 stable, in_ready=0. A new in_valid pulse during DONE is ignored. out_ready=1 -> IDLE next cycle.
5. Reset mid-MUL: accept err_mag=300, act=64, then rst=1 on the 4th MUL cycle -> next cycle in_ready=1, out_valid=0, delta=0, sign=0. A following transaction err_mag=100, act=32, lr_shift=0 -> delta=100, sign=0.
6. Back-to-back: two transactions with out_ready tied high (err_mag=64, act=96, lr_shift=1 -> delta=96; then err_mag=10, act=16, lr_shift=0 -> delta=5) -> results are in order, and in_ready is low during each computation.
